// File: rtl/per_byte_packer_pkg.sv
// Shared types and constants for the nibble-to-byte packer and its byte FIFO.
package per_byte_packer_pkg;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_t;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 2 * NIBBLE_W;

    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/per_byte_fifo.sv
// Byte FIFO for the packer: registered storage, wrapping pointers, occupancy count.
module per_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3,
    parameter int W     = 8
) (
    input  logic          per_clock,
    input  logic          per_reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          head_valid,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign head_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    // full/empty come from the pre-edge count, so a full FIFO never takes a
    // same-cycle push even when a pop happens at that edge.
    assign do_push    = push && !full;
    assign do_pop     = pop && head_valid;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge per_clock) begin
        if (!per_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/per_byte_packer.sv
// Packs nibble pairs (low nibble first) into bytes queued in per_byte_fifo.
// Optional per-byte even parity output when PER_BYTE_PACKER_PARITY_EN is defined.
module per_byte_packer
    import per_byte_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                per_clock,
    input  logic                per_reset,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] in_nibble,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    output logic [BYTE_W-1:0]   out_byte,
    input  logic                out_ready,
    output logic [CW-1:0]       fifo_count,
    output logic                overflow
`ifdef PER_BYTE_PACKER_PARITY_EN
    ,
    output logic                out_parity
`endif
);

`ifdef PER_BYTE_PACKER_PARITY_EN
    localparam int EW = BYTE_W + 1;
`else
    localparam int EW = BYTE_W;
`endif

    pack_state_t         state;
    pack_state_t         state_next;
    logic [NIBBLE_W-1:0] hold;
    logic                fifo_full;
    logic                accept;
    logic                push;
    logic [BYTE_W-1:0]   push_byte;
    logic [EW-1:0]       push_entry;
    logic [EW-1:0]       head_entry;

    assign accept    = in_valid && in_ready;
    assign push_byte = {in_nibble, hold};

`ifdef PER_BYTE_PACKER_PARITY_EN
    assign push_entry = {even_parity(push_byte), push_byte};
    assign out_parity = head_entry[BYTE_W];
`else
    assign push_entry = push_byte;
`endif
    assign out_byte = head_entry[BYTE_W-1:0];

    always_ff @(posedge per_clock) begin
        if (!per_reset || flush) begin
            state <= LOW;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = (state == LOW) ? HIGH : LOW;
        end
    end

    // Nothing is accepted while reset or flush is asserted.
    always_comb begin
        in_ready = 1'b0;
        push     = 1'b0;
        if (per_reset && !flush) begin
            case (state)
                LOW:  in_ready = 1'b1;
                HIGH: begin
                    in_ready = !fifo_full;
                    push     = in_valid && !fifo_full;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge per_clock) begin
        if (!per_reset || flush) begin
            hold     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept && state == LOW) begin
                hold <= in_nibble;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    per_byte_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .W     (EW)
    ) u_fifo (
        .per_clock  (per_clock),
        .per_reset  (per_reset),
        .flush      (flush),
        .push       (push),
        .push_data  (push_entry),
        .pop        (out_ready),
        .head_data  (head_entry),
        .head_valid (out_valid),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule
